number_display: RTL
===================

// Module: number_display
// PURPOSE
//  Downstream consumer of slider_increment. Selects number_1 or number_2, converts the 14-bit
//  binary operand to 4-digit BCD (sequential double-dabble, one shift/cycle), and drives a
//  4-digit multiplexed common-anode 7-segment display. Also exports the latched BCD word.
// PARAMETERS
//  CLK_DIV  50000  clk cycles per digit refresh slot (>=2)
//  WIDTH    14     operand width; fixed, matches slider_increment outputs
// PORTS
//  clk             in   1   system clock, all logic on rising edge
//  rst_ext_n       in   1   synchronous active-low reset
//  number_1        in   14  operand A (binary, from slider_increment)
//  number_2        in   14  operand B (binary, from slider_increment)
//  display_select  in   1   0 = show number_1, 1 = show number_2
//  bcd             out  16  latched BCD {thousands,hundreds,tens,units}; 16'hFFFF = overflow
//  bcd_valid       out  1   one-cycle pulse when bcd is updated
//  seg_n           out  7   segments {g,f,e,d,c,b,a}, active low
//  an_n            out  4   digit enables, active low, bit0 = units
// BEHAVIOUR
//  - Reset (rst_ext_n=0 at edge): FSM->LOAD, bcd=0, bcd_valid=0, digit idx=0, refresh cnt=0,
//    display_on=0, seg_n=7'h7F, an_n=4'hF. Reset mid-conversion aborts it; no bcd_valid.
//  - FSM free-runs LOAD->SHIFT x14->DONE->LOAD; period 16 cycles.
//    LOAD: capture display_select ? number_2 : number_1 into shift reg; clear BCD scratch.
//    SHIFT: per cycle add 3 to every scratch nibble >=5, then shift left 1 (MSB of operand in).
//    DONE: bcd <= scratch (or 16'hFFFF if captured operand > 9999); bcd_valid=1 this cycle only;
//    display_on <= 1.
//  - First bcd_valid 16 cycles after reset release. Input/select change reflected in bcd
//    within 32 cycles. Operand is sampled only in LOAD; changes during SHIFT affect next pass.
//  - Refresh: cnt counts 0..CLK_DIV-1, wraps; on wrap idx = idx+1 mod 4 (3->0).
//  - Outputs registered (1 cycle after idx/bcd). display_on=0: seg_n=7'h7F, an_n=4'hF.
//    display_on=1: an_n = ~(4'b0001<<idx); seg_n = decode(bcd nibble idx).
//  - Decode: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex, seg_n);
//    F = dash 7'h3F; A..E = blank 7'h7F.
//  - Overflow (operand 10000..16383): all four digits show dash.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero digit show 7'h7F
//    (an_n still cycles); units digit never blanked; dashes never blanked.
//  Not defined: all four digits always shown, leading zeros displayed as '0' (7'h40).
// TESTING (CLK_DIV=4 in bench)
//  1 rst_ext_n low 5 cycles, release, operands 0 -> seg_n=7F/an_n=F until bcd_valid at cycle 16;
//    then bcd=16'h0000, an_n cycles E,D,B,7 every 4 cycles.
//  2 number_1=1234, select=0 -> bcd=16'h1234 within 32 cycles; an_n=E shows 19, D 30, B 24, 7 79.
//  3 number_2=9999, select=1 -> bcd=16'h9999; then number_2=10000 -> bcd=16'hFFFF, all digits 3F.
//  4 number_1=5, number_2=42, toggle select 1 during SHIFT -> next bcd_valid bcd=0005,
//    following bcd_valid bcd=0042.
//  5 number_1=7: with LEADING_ZERO_BLANK_EN digits 3..1 seg_n=7F, units 78;
//    without macro digits 3..1 seg_n=40.
//  6 assert rst_ext_n low mid-SHIFT -> next edge all outputs at reset values, no bcd_valid;
//    after release conversion restarts, bcd_valid 16 cycles later.

Source files
------------

// File: rtl/number_display_if.sv
// Operand/result bundle between the slider block, number_display and its observers.
// Carries the two binary operands and select in; latched BCD, valid pulse and LED drive out.
// Optional feature of the consumer (LEADING_ZERO_BLANK_EN) does not change this bundle.
interface number_display_if;
  logic [13:0] number_1;
  logic [13:0] number_2;
  logic        display_select;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;

  modport master (
    output number_1, number_2, display_select,
    input  bcd, bcd_valid, seg_n, an_n
  );

  modport slave (
    input  number_1, number_2, display_select,
    output bcd, bcd_valid, seg_n, an_n
  );
endinterface

// File: rtl/number_display.sv
// Binary->BCD (serial double-dabble) plus 4-digit multiplexed common-anode 7-seg driver.
// Latency: new bcd every 16 cycles (LOAD, 14x SHIFT, DONE); seg_n/an_n registered 1 cycle after idx/bcd.
// No backpressure: free-running; operand sampled only in LOAD. Macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module number_display #(
  parameter int CLK_DIV = 50000,
  parameter int WIDTH   = 14
) (
  input  logic          clk,
  input  logic          rst_ext_n,
  number_display_if.slave io
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       shift_cnt;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] sreg;
  logic [15:0]      scratch;
  logic [15:0]      scratch_adj;
  logic             ovf;
  logic [15:0]      bcd_q;
  logic             bcd_valid_q;
  logic             display_on;
  logic [CW-1:0]    cnt;
  logic [1:0]       idx;
  logic [3:0]       digit;
  logic             blank;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hF:    s = 7'h3F;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Operand mux; only consumed while in LOAD.
  always_comb begin
    operand = io.display_select ? io.number_2 : io.number_1;
  end

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_ext_n) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one LOAD, WIDTH shifts, one DONE, repeat forever.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (shift_cnt == 4'(WIDTH - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Conversion datapath and result latch; overflow is judged on the captured operand.
  always_ff @(posedge clk) begin
    if (!rst_ext_n) begin
      shift_cnt   <= 4'd0;
      sreg        <= '0;
      scratch     <= 16'h0000;
      ovf         <= 1'b0;
      bcd_q       <= 16'h0000;
      bcd_valid_q <= 1'b0;
      display_on  <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          sreg      <= operand;
          scratch   <= 16'h0000;
          ovf       <= (operand > WIDTH'(9999));
          shift_cnt <= 4'd0;
        end
        S_SHIFT: begin
          scratch   <= {scratch_adj[14:0], sreg[WIDTH-1]};
          sreg      <= {sreg[WIDTH-2:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
        end
        S_DONE: begin
          bcd_q       <= ovf ? 16'hFFFF : scratch;
          bcd_valid_q <= 1'b1;
          display_on  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Refresh timer: advance the scanned digit each time the slot counter wraps.
  always_ff @(posedge clk) begin
    if (!rst_ext_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Pick the scanned nibble and decide whether it is a blanked leading zero.
  always_comb begin
    digit = 4'h0;
    blank = 1'b0;
    case (idx)
      2'd0: digit = bcd_q[3:0];
      2'd1: digit = bcd_q[7:4];
      2'd2: digit = bcd_q[11:8];
      2'd3: digit = bcd_q[15:12];
      default: digit = 4'h0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // Units never blank; an overflow word has nonzero nibbles so dashes survive.
    case (idx)
      2'd1: blank = (bcd_q[15:4] == 12'h000);
      2'd2: blank = (bcd_q[15:8] == 8'h00);
      2'd3: blank = (bcd_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  // Registered LED drive; dark until the first result has been latched.
  always_ff @(posedge clk) begin
    if (!rst_ext_n) begin
      seg_q <= 7'h7F;
      an_q  <= 4'hF;
    end else if (!display_on) begin
      seg_q <= 7'h7F;
      an_q  <= 4'hF;
    end else begin
      seg_q <= blank ? 7'h7F : seg_decode(digit);
      an_q  <= ~(4'b0001 << idx);
    end
  end

  assign io.bcd       = bcd_q;
  assign io.bcd_valid = bcd_valid_q;
  assign io.seg_n     = seg_q;
  assign io.an_n      = an_q;

endmodule
